// File: rtl/shifter_pkg.sv
// Shared types for the pipelined barrel shifter.
// Holds the shift-mode encoding and the per-stage control payload that
// travels alongside the data word (valid bit and mode).
package shifter_pkg;

   // Shift operation carried with every beat.
   typedef enum logic [1:0] {
      SRL = 2'b00,   // logical right, zero fill
      SRA = 2'b01,   // arithmetic right, operand-MSB fill
      SLL = 2'b10,   // logical left, zero fill from the LSB side
      ROR = 2'b11    // rotate right
   } shift_mode_e;

   // Control slot registered in every stage next to the data word. An
   // invalid slot moves through the pipe exactly like a valid one.
   typedef struct packed {
      logic        vld;
      shift_mode_e mode;
   } stage_ctl_t;

endpackage

// File: rtl/shift_stage.sv
// shift_stage: one layer of the log shifter; shifts by SHIFT when sel = 1, then registers.
// Latency: 1 cycle.
// Backpressure: the register loads only when en = 1, otherwise the slot holds.
// Ports: en (global advance), sel (amount bit owned by this layer), fill (SRA fill bit),
//        d_in/ctl_in (incoming slot), d_q/ctl_q (registered slot).
module shift_stage
   import shifter_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SHIFT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             sel,
   input  logic             fill,
   input  logic [WIDTH-1:0] d_in,
   input  stage_ctl_t       ctl_in,
   output logic [WIDTH-1:0] d_q,
   output stage_ctl_t       ctl_q
);

   logic [WIDTH-1:0] d_nxt;

   // SHIFT is always below WIDTH (largest layer is WIDTH/2), so every slice
   // below is non-empty.
   always_comb begin
      d_nxt = d_in;
      if (sel) begin
         case (ctl_in.mode)
            SRL: d_nxt = {{SHIFT{1'b0}}, d_in[WIDTH-1:SHIFT]};
            SRA: d_nxt = {{SHIFT{fill}}, d_in[WIDTH-1:SHIFT]};
            SLL: d_nxt = {d_in[WIDTH-1-SHIFT:0], {SHIFT{1'b0}}};
            ROR: d_nxt = {d_in[SHIFT-1:0], d_in[WIDTH-1:SHIFT]};
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_q   <= '0;
         ctl_q <= '{vld: 1'b0, mode: SRL};
      end else if (en) begin
         d_q   <= d_nxt;
         ctl_q <= ctl_in;
      end
   end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe: pipelined log barrel shifter (SRL/SRA/SLL/ROR), valid/ready stream.
// Latency: SHW cycles when unstalled; one beat per cycle throughput.
// Backpressure: global stall, every stage holds while out_valid & ~out_ready; in_ready = out_ready | ~out_valid.
// Ports: in_valid/in_ready/in_data/in_amt/in_mode (operand beat),
//        out_valid/out_ready/out_data/out_mode (result beat, mode echoed).
module barrel_shifter_pipe
   import shifter_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_amt,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       out_mode
);

   logic advance;

   // A stall only exists when a finished result is blocked, so the whole
   // pipe moves together; bubbles are never squeezed out.
   assign advance  = out_ready | ~out_valid;
   assign in_ready = advance;

   // Stage k consumes amount bit SHW-1-k (largest shift first). The amount
   // bits still to be used shrink by one per stage, so stage k only carries
   // SHW-k of them and the last stage carries just its own select bit.
   for (genvar k = 0; k < SHW; k++) begin : stg
      logic [SHW-1-k:0] amt_in;
      logic             fill_in;
      logic [WIDTH-1:0] d_in;
      stage_ctl_t       ctl_in;
      logic [WIDTH-1:0] d_q;
      stage_ctl_t       ctl_q;

      if (k == 0) begin : g_src
         // When advance = 1, in_ready = 1, so in_valid alone marks acceptance.
         assign amt_in      = in_amt;
         assign fill_in     = in_data[WIDTH-1];
         assign d_in        = in_data;
         assign ctl_in.vld  = in_valid;
         assign ctl_in.mode = shift_mode_e'(in_mode);
      end else begin : g_src
         logic [SHW-1-k:0] amt_q;
         logic             fill_q;

         // Remaining amount bits and the captured operand MSB ride with the
         // slot; they are only needed up to the stage that consumes them.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               amt_q  <= '0;
               fill_q <= 1'b0;
            end else if (advance) begin
               amt_q  <= stg[k-1].amt_in[SHW-1-k:0];
               fill_q <= stg[k-1].fill_in;
            end
         end

         assign amt_in  = amt_q;
         assign fill_in = fill_q;
         assign d_in    = stg[k-1].d_q;
         assign ctl_in  = stg[k-1].ctl_q;
      end

      shift_stage #(
         .WIDTH (WIDTH),
         .SHIFT (1 << (SHW-1-k))
      ) u_stage (
         .clk    (clk),
         .rst_n  (rst_n),
         .en     (advance),
         .sel    (amt_in[SHW-1-k]),
         .fill   (fill_in),
         .d_in   (d_in),
         .ctl_in (ctl_in),
         .d_q    (d_q),
         .ctl_q  (ctl_q)
      );
   end

   assign out_valid = stg[SHW-1].ctl_q.vld;
   assign out_mode  = stg[SHW-1].ctl_q.mode;
   assign out_data  = stg[SHW-1].d_q;

endmodule
